// File: rtl/cam_capture_fmt.sv
// Camera capture: pairs sensor bytes into pixels, reformats them and writes them to the frame RAM.
// Optional 2:1 decimation in both axes when CAM_DECIM2_EN is defined.
module cam_capture_fmt #(
    parameter int AW    = 15,
    parameter int DW    = 12,
    parameter int IMG_W = 160,
    parameter int IMG_H = 120
) (
    input  logic          CAM_pclk,
    input  logic          rst,
    input  logic [7:0]    CAM_px_data,
    input  logic          CAM_vsync,
    input  logic          CAM_href,
    input  logic [1:0]    fmt_sel,
    output logic          DP_RAM_regW,
    output logic [AW-1:0] DP_RAM_addr_in,
    output logic [DW-1:0] DP_RAM_data_in,
    output logic          frame_done
);

    localparam int CW = $clog2(IMG_W + 1);
    localparam int RW = $clog2(IMG_H + 1);
    localparam logic [CW-1:0] COL_LIM   = CW'(IMG_W);
    localparam logic [RW-1:0] ROW_LIM   = RW'(IMG_H);
    localparam logic [AW-1:0] ADDR_STEP = AW'(IMG_W);
    localparam logic [AW-1:0] ADDR_LAST = AW'(IMG_W * IMG_H - 1);

    typedef enum logic [2:0] {S_SYNC, S_VBLANK, S_LINE, S_B1, S_B2} state_t;

    function automatic logic [11:0] fmt_pix(input logic [1:0] f, input logic [7:0] b1,
                                            input logic [7:0] b2);
        case (f)
            2'd1:    fmt_pix = {b1[7:4], b1[2:0], b2[7], b2[4:1]};
            2'd2:    fmt_pix = {4'b0, b1[7:5], b1[2:0], b2[4:3]};
            default: fmt_pix = {b1[3:0], b2};
        endcase
    endfunction

    state_t        state_q, state_d;
    logic [1:0]    fmt_q, fmt_d;
    logic [7:0]    b1_q, b1_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [AW-1:0] base_q, base_d;
    logic          regw_q, regw_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic          done_q, done_d;

    logic pix_evt, line_evt, frame_start;
    logic pix_keep, col_adv, row_adv;
    logic [AW-1:0] pix_addr;

`ifdef CAM_DECIM2_EN
    // Column/line parity: only even sensor columns of even sensor lines are kept.
    logic cpar_q, cpar_d, rpar_q, rpar_d;

    always_comb begin
        cpar_d = cpar_q;
        rpar_d = rpar_q;
        if (frame_start) begin
            cpar_d = 1'b0;
            rpar_d = 1'b0;
        end else if (line_evt) begin
            cpar_d = 1'b0;
            rpar_d = ~rpar_q;
        end else if (pix_evt) begin
            cpar_d = ~cpar_q;
        end
    end

    always_ff @(posedge CAM_pclk) begin
        if (rst) begin
            cpar_q <= 1'b0;
            rpar_q <= 1'b0;
        end else begin
            cpar_q <= cpar_d;
            rpar_q <= rpar_d;
        end
    end

    assign pix_keep = ~cpar_q & ~rpar_q;
    assign col_adv  = cpar_q;
    assign row_adv  = rpar_q;
`else
    assign pix_keep = 1'b1;
    assign col_adv  = 1'b1;
    assign row_adv  = 1'b1;
`endif

    assign pix_addr = base_q + AW'(col_q);

    always_comb begin
        state_d     = state_q;
        fmt_d       = fmt_q;
        b1_d        = b1_q;
        col_d       = col_q;
        row_d       = row_q;
        base_d      = base_q;
        regw_d      = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        done_d      = 1'b0;
        pix_evt     = 1'b0;
        line_evt    = 1'b0;
        frame_start = 1'b0;

        case (state_q)
            S_SYNC: if (CAM_vsync) state_d = S_VBLANK;
            S_VBLANK: begin
                if (!CAM_vsync) begin
                    fmt_d       = fmt_sel;
                    col_d       = '0;
                    row_d       = '0;
                    base_d      = '0;
                    frame_start = 1'b1;
                    state_d     = S_LINE;
                end
            end
            // LINE behaves like B1 except that idle href does not end a line.
            S_LINE, S_B1: begin
                if (CAM_vsync) begin
                    state_d = S_VBLANK;
                end else if (CAM_href) begin
                    b1_d    = CAM_px_data;
                    state_d = S_B2;
                end else if (state_q == S_B1) begin
                    line_evt = 1'b1;
                    state_d  = S_LINE;
                end
            end
            S_B2: begin
                if (CAM_vsync) begin
                    state_d = S_VBLANK;
                end else if (CAM_href) begin
                    pix_evt = 1'b1;
                    state_d = S_B1;
                end else begin
                    line_evt = 1'b1;
                    state_d  = S_LINE;
                end
            end
            default: state_d = S_SYNC;
        endcase

        // Counters saturate at the limits: anything past them is clipped anyway.
        if (pix_evt) begin
            if (pix_keep && col_q < COL_LIM && row_q < ROW_LIM) begin
                regw_d = 1'b1;
                addr_d = pix_addr;
                data_d = DW'(fmt_pix(fmt_q, b1_q, CAM_px_data));
                done_d = (pix_addr == ADDR_LAST);
            end
            if (col_adv && col_q < COL_LIM) col_d = col_q + CW'(1);
        end

        if (line_evt) begin
            col_d = '0;
            if (row_adv && row_q < ROW_LIM) begin
                row_d  = row_q + RW'(1);
                base_d = base_q + ADDR_STEP;
            end
        end
    end

    always_ff @(posedge CAM_pclk) begin
        if (rst) begin
            state_q <= S_SYNC;
            fmt_q   <= '0;
            b1_q    <= '0;
            col_q   <= '0;
            row_q   <= '0;
            base_q  <= '0;
            regw_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            fmt_q   <= fmt_d;
            b1_q    <= b1_d;
            col_q   <= col_d;
            row_q   <= row_d;
            base_q  <= base_d;
            regw_q  <= regw_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign DP_RAM_regW    = regw_q;
    assign DP_RAM_addr_in = addr_q;
    assign DP_RAM_data_in = data_q;
    assign frame_done     = done_q;

endmodule
